// File: rtl/md_unit_ctrl.sv
// HI/LO multiply-divide unit controller: latches operands on start, runs a
// fixed-latency busy window, then writes the 64-bit result into HI/LO.
module md_unit_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        mt_we,
  input  logic        mt_sel,
  input  logic [31:0] mt_data,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CW = 4;
  localparam int unsigned DW = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d;
  logic [DW-1:0] hi_q, hi_d, lo_q, lo_d;

  logic [2*DW-1:0] a_ext, b_ext, prod;
  logic [DW-1:0]   a_mag, b_mag, divisor, q_mag, r_mag, quo, rem;
  logic            sgn, div_zero;

  // Datapath on latched operands; op_q[0] selects the unsigned variant.
  always_comb begin
    sgn      = ~op_q[0];
    a_ext    = sgn ? {{DW{a_q[DW-1]}}, a_q} : {{DW{1'b0}}, a_q};
    b_ext    = sgn ? {{DW{b_q[DW-1]}}, b_q} : {{DW{1'b0}}, b_q};
    prod     = a_ext * b_ext;
    // Magnitude division keeps 0x80000000 / -1 well defined (wraps).
    a_mag    = (sgn && a_q[DW-1]) ? DW'(-a_q) : a_q;
    b_mag    = (sgn && b_q[DW-1]) ? DW'(-b_q) : b_q;
    div_zero = (b_q == '0);
    divisor  = div_zero ? DW'(1) : b_mag;
    q_mag    = a_mag / divisor;
    r_mag    = a_mag % divisor;
    quo      = (sgn && (a_q[DW-1] ^ b_q[DW-1])) ? DW'(-q_mag) : q_mag;
    rem      = (sgn && a_q[DW-1]) ? DW'(-r_mag) : r_mag;
  end

  // Next-state and register updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = md_op;
          a_d     = src_a;
          b_d     = src_b;
          cnt_d   = md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          state_d = RUN;
        end else if (mt_we) begin
          if (mt_sel) hi_d = mt_data;
          else        lo_d = mt_data;
        end
      end
      RUN: begin
        if (cnt_q <= CW'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (op_q[1]) begin
            if (!div_zero) begin
              hi_d = rem;
              lo_d = quo;
            end
          end else begin
            hi_d = prod[2*DW-1:DW];
            lo_d = prod[DW-1:0];
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy  = (state_q == RUN);
  assign stall = busy | start;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: doc/md_unit_ctrl.md
MD_UNIT_CTRL -- requirements
Module: md_unit_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for mult/multu (legal range 1-15).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for div/divu (legal range 1-15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  issue a multiply/divide this cycle.
REQ-006 SHALL have port md_op  input  2  operation select: 00 mult, 01 multu, 10 div, 11 divu.
REQ-007 SHALL have port src_a  input  32  rs operand.
REQ-008 SHALL have port src_b  input  32  rt operand.
REQ-009 SHALL have port mt_we  input  1  mthi/mtlo write strobe.
REQ-010 SHALL have port mt_sel  input  1  mt target: 1 HI, 0 LO.
REQ-011 SHALL have port mt_data  input  32  mthi/mtlo data.
REQ-012 SHALL have port busy  output  1  operation in progress (registered).
REQ-013 SHALL have port stall  output  1  pipeline stall request for HI/LO users: busy OR start (combinational).
REQ-014 SHALL have port hi  output  32  HI register.
REQ-015 SHALL have port lo  output  32  LO register.

Function
REQ-016 SHALL implement two states: IDLE (busy=0) and RUN (busy=1).
REQ-017 IDLE + start=1 at edge k: SHALL latch md_op, src_a, src_b; load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
REQ-018 RUN: counter SHALL decrement by 1 per edge; on the edge where counter==1, SHALL write HI/LO and return to IDLE.
REQ-019 Latency: start sampled at edge k; busy SHALL be 1 after edges k..k+N-1 and 0 after edge k+N; hi/lo SHALL show the result after edge k+N (N = selected cycle count).
REQ-020 mult: {hi,lo} SHALL equal the signed 64-bit product of src_a and src_b; multu: the unsigned 64-bit product.
REQ-021 div: lo SHALL equal the signed quotient truncated toward zero; hi SHALL equal the remainder, sign of dividend. divu: unsigned quotient and remainder.
REQ-022 div/divu with src_b==0: SHALL run the full DIV_CYCLES; hi and lo SHALL remain unchanged.
REQ-023 div with 0x80000000 / 0xFFFFFFFF: lo SHALL be 0x80000000 and hi 0x00000000 (wrap, no trap).
REQ-024 start while RUN: SHALL be ignored (no relatch, no counter reload).
REQ-025 mt_we in IDLE with start=0: SHALL write mt_data to HI (mt_sel=1) or LO (mt_sel=0) at that edge; the other register is unchanged.
REQ-026 mt_we while RUN: SHALL be ignored.
REQ-027 mt_we and start both 1 in IDLE: start SHALL win; the mt write SHALL be discarded.
REQ-028 stall SHALL equal busy | start with no register stage.
REQ-029 Operand inputs SHALL be ignored outside the start edge; the result depends only on latched values.

Reset
REQ-030 reset=1 SHALL asynchronously force IDLE, busy=0, counter=0, hi=0, lo=0, latched operands=0.
REQ-031 reset asserted during RUN SHALL abort the operation: no HI/LO write afterwards, and busy=0 immediately.
REQ-032 After reset deasserts, the first rising edge SHALL accept start or mt_we normally.

Verification
REQ-033 multu 0xFFFFFFFF*0x2, N=5 -> busy high 5 cycles, then hi=0x00000001, lo=0xFFFFFFFE.
REQ-034 mult -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB after 5 cycles; div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 cycles.
REQ-035 divu 5/0 with hi=0x11, lo=0x22 preloaded via mt -> busy 10 cycles, hi=0x11, lo=0x22.
REQ-036 start at cycle 2 of RUN with new operands, plus mt_we during RUN -> both ignored; the original result is written at the original edge.
REQ-037 Same-edge start and mt_we -> operation starts, mt data is not written; stall=1 on the start cycle with busy=0.
REQ-038 reset pulse (3 ns, off-edge) at cycle 3 of a div -> busy=0, hi=lo=0 immediately; no write at the original completion edge.
